// File: rtl/csr_responder_bank.sv
// CSR target bank: one register per one-hot strobe slot, either read/write control or sticky W1C status.
// Optional: define CSR_RESPONDER_STATUS_SYNC_EN to pass status_i through a two-flop synchronizer.
module csr_responder_bank #(
    parameter int CSR_DATA_BUS_WIDTH   = 32,
    parameter int CSR_STROBE_BUS_WIDTH = 8,
    parameter logic [CSR_STROBE_BUS_WIDTH-1:0] STATUS_MASK =
        CSR_STROBE_BUS_WIDTH'(1) << (CSR_STROBE_BUS_WIDTH - 1),
    parameter logic [CSR_DATA_BUS_WIDTH-1:0]   CTRL_RESET_VALUE = '0
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [CSR_STROBE_BUS_WIDTH-1:0]                csr_stb_i,
    input  logic [CSR_DATA_BUS_WIDTH-1:0]                  csr_wdata_i,
    output logic [CSR_STROBE_BUS_WIDTH*CSR_DATA_BUS_WIDTH-1:0] csr_rdata_o,
    output logic [CSR_STROBE_BUS_WIDTH*CSR_DATA_BUS_WIDTH-1:0] ctrl_o,
    output logic [CSR_STROBE_BUS_WIDTH-1:0]                wr_pulse_o,
    input  logic [CSR_STROBE_BUS_WIDTH*CSR_DATA_BUS_WIDTH-1:0] status_i,
    output logic [15:0]                                    err_count_o
);

    localparam int W = CSR_DATA_BUS_WIDTH;
    localparam int S = CSR_STROBE_BUS_WIDTH;

    logic         stb_any;
    logic         stb_multi;
    logic         stb_accept;
    logic [S*W-1:0] status_evt;
    logic [S-1:0] unused_evt;

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign stb_any    = |csr_stb_i;
    assign stb_multi  = |(csr_stb_i & (csr_stb_i - S'(1)));
    assign stb_accept = stb_any & ~stb_multi;

`ifdef CSR_RESPONDER_STATUS_SYNC_EN
    logic [S*W-1:0] sync_q1;
    logic [S*W-1:0] sync_q2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= status_i;
            sync_q2 <= sync_q1;
        end
    end

    assign status_evt = sync_q2;
`else
    assign status_evt = status_i;
`endif

    for (genvar i = 0; i < S; i++) begin : g_slot
        logic [W-1:0] slot_q;
        logic         wr_hit;

        assign wr_hit = stb_accept & csr_stb_i[i];

        if (STATUS_MASK[i]) begin : g_status
            // Set is OR-ed in after the clear so a simultaneous event wins.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    slot_q <= '0;
                end else begin
                    slot_q <= (slot_q & ~(wr_hit ? csr_wdata_i : '0)) | status_evt[i*W +: W];
                end
            end

            assign ctrl_o[i*W +: W] = '0;
            assign unused_evt[i]    = 1'b0;
        end else begin : g_ctrl
            // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    slot_q <= CTRL_RESET_VALUE;
                end else if (wr_hit) begin
                    slot_q <= csr_wdata_i;
                end
            end

            assign ctrl_o[i*W +: W] = slot_q;
            assign unused_evt[i]    = ^status_evt[i*W +: W];
        end

        assign csr_rdata_o[i*W +: W] = slot_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_pulse_o <= '0;
        end else begin
            wr_pulse_o <= stb_accept ? csr_stb_i : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count_o <= '0;
        end else if (stb_multi && (err_count_o != 16'hFFFF)) begin
            err_count_o <= err_count_o + 16'd1;
        end
    end

endmodule
